mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have one parameter: N, default 16, operand width in bits.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port start  input  1  request to begin a multiply; sampled on rising clk.
REQ-006 Port A  input  N  unsigned multiplicand; sampled only when a start is accepted.
REQ-007 Port B  input  N  unsigned multiplier; sampled only when a start is accepted.
REQ-008 Port busy  output  1  high while a multiply is in progress.
REQ-009 Port done  output  1  single-cycle pulse marking a valid product.
REQ-010 Port P_hi  output  N  upper N bits of the 2N-bit product; feeds the downstream 2:1 word-select mux X/Y input.
REQ-011 Port P_lo  output  N  lower N bits of the 2N-bit product; feeds the downstream 2:1 word-select mux.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 In IDLE, a rising edge with start=1 SHALL capture A and B, clear the 2N-bit accumulator and the iteration counter, and move to BUSY.
REQ-014 In IDLE with start=0, the state and all outputs SHALL hold.
REQ-015 BUSY SHALL last exactly N cycles, with one shift-add iteration per cycle.
REQ-016 Each iteration: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator, with the carry kept; then shift the accumulator and the multiplier right by 1.
REQ-017 The arithmetic SHALL be unsigned with no truncation; the final 2N-bit result SHALL equal A*B exactly.
REQ-018 The iteration counter SHALL be wide enough to count to N (clog2(N)+1 bits) and SHALL NOT wrap during BUSY.
REQ-019 After the Nth iteration, the FSM SHALL enter DONE for exactly one cycle, with done=1 and P_hi/P_lo valid.
REQ-020 DONE SHALL always return to IDLE on the next edge.
REQ-021 Latency: done SHALL rise N+1 cycles after the edge on which start was accepted.
REQ-022 busy SHALL be 1 in BUSY only, and 0 in IDLE and DONE.
REQ-023 P_hi/P_lo SHALL be registered and updated only on entry to DONE.
REQ-024 P_hi/P_lo SHALL hold their value through IDLE and the whole of the next BUSY, until the next DONE.
REQ-025 start asserted in BUSY or DONE SHALL be ignored, with no restart, no operand recapture and no queuing.
REQ-026 Changes on A and B outside the accepting edge SHALL have no effect on the result.
REQ-027 start held high continuously SHALL produce back-to-back multiplies: accept, N BUSY cycles, DONE, IDLE, then accept again.
REQ-028 Zero operands SHALL still take the full N BUSY cycles; there is no early termination.

Reset
REQ-029 While rst_n=0, independent of clk: state=IDLE, busy=0, done=0, P_hi=0, P_lo=0, and the accumulator, operand registers and counter=0.
REQ-030 Reset asserted mid-BUSY SHALL abort the operation, with no done pulse; after release, the FSM waits in IDLE for a new start.
REQ-031 The first accepting edge after rst_n rises SHALL be the first edge on which rst_n=1 and start=1.

Verification
REQ-032 Basic case: N=16, A=3, B=5, one-cycle start -> busy for 16 cycles; done pulses at cycle 17; P_hi=0x0000, P_lo=0x000F.
REQ-033 Maximum case: A=0xFFFF, B=0xFFFF -> P_hi=0xFFFE, P_lo=0x0001 at done.
REQ-034 Zero operand and hold check:
- A=0x1234, B=0 -> P_hi=P_lo=0, with full 16-cycle latency.
- The previous product is held on P_hi/P_lo until this done.
REQ-035 Ignored restart: start A=7, B=9; re-assert start with A=2, B=2 at BUSY cycle 5 -> a single done with P_lo=0x003F, and no second operation.
REQ-036 Reset mid-operation: rst_n pulsed low at BUSY cycle 8 -> outputs are immediately 0, no done pulse, and the next start A=10, B=10 gives P_lo=0x0064.
REQ-037 Back-to-back operation: start held high with A=0x0100, B=0x0100 -> done every 18 cycles, each with P_hi=0x0001, P_lo=0x0000.

Source files
------------

// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq
//
// This is an unsigned sequential multiplier that uses the shift-add method.
// It processes one bit of the multiplier per clock, so each multiply occupies
// N cycles in BUSY. After that it spends one cycle in DONE, where the 2N-bit
// product is presented on P_hi/P_lo. The product registers keep that value
// until the next multiply completes.
//
// Parameters
//   N      operand width in bits (default 16)
//
// Ports
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   start  request to begin a multiply; only honoured in IDLE
//   A      unsigned multiplicand, captured on the accepting edge
//   B      unsigned multiplier, captured on the accepting edge
//   busy   high while the shift-add iterations run
//   done   one-cycle pulse when P_hi/P_lo take a new product
//   P_hi   upper N bits of the product
//   P_lo   lower N bits of the product
// ---------------------------------------------------------------------------
module mult_seq #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] P_hi,
   output logic [N-1:0] P_lo
);

   // The counter can reach N without wrapping. Its last value in BUSY is N-1.
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state;
   logic [N-1:0]    mcand;
   logic [N-1:0]    mplier;
   logic [2*N-1:0]  acc;
   logic [CW-1:0]   cnt;

   logic [N:0]      upperSum;
   logic [2*N-1:0]  accNext;

   // This block computes one shift-add step. When the multiplier LSB is set,
   // the multiplicand is added into the upper half of the accumulator. The
   // sum is one bit wider, so the carry is kept. The whole accumulator then
   // shifts right, and that carry becomes the new MSB. As a result, no
   // product bit is lost.
   always_comb begin
      upperSum = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : {(N+1){1'b0}});
      accNext  = {upperSum, acc[N-1:1]};
   end

   // This is the control FSM and datapath. All outputs are registered here.
   // A start is only honoured in IDLE, so requests that arrive in BUSY or
   // DONE are dropped rather than queued. The product registers are written
   // only on the transition into DONE. For that reason they hold their value
   // through IDLE and through the whole of the following BUSY phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         P_hi   <= '0;
         P_lo   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= A;
                  mplier <= B;
                  acc    <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= BUSY;
               end
            end

            BUSY: begin
               acc    <= accNext;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // The last iteration is done on the edge that leaves BUSY. A
               // zero multiplier still runs all N iterations.
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  P_hi  <= accNext[2*N-1:N];
                  P_lo  <= accNext[N-1:0];
                  state <= DONE;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_seq
//
// This is a directed testbench for mult_seq with N=16. The expected products
// are hand-computed constants. Outputs are sampled on the falling clock edge,
// and inputs are driven there too.
// ---------------------------------------------------------------------------
module tb_mult_seq;

   localparam int N = 16;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] P_hi;
   logic [N-1:0] P_lo;

   int checks;
   int errors;
   logic [N-1:0] prevHi;
   logic [N-1:0] prevLo;

   mult_seq #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P_hi  (P_hi),
      .P_lo  (P_lo)
   );

   // This generates a free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // This task runs one comparison and counts it. A failure is also counted
   // and reported.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // This task runs a full multiply and checks it cycle by cycle.
   // - Operands are scrambled right after the accepting edge.
   // - Busy, done and the held product are checked on every BUSY cycle.
   // - If glitch is non-zero, start is re-pulsed with A=2, B=2 on that BUSY
   //   cycle.
   // - The done cycle and the cycle after it are checked too.
   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] expHi, input logic [N-1:0] expLo,
                                input int glitch, input string tag);
      @(negedge clk);
      start = 1'b1;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
      A     = ~a;
      B     = ~b;
      for (int k = 1; k <= N; k++) begin
         if (k > 1) @(negedge clk);
         checkOutput({tag, " busy"}, 32'(busy), 32'd1);
         checkOutput({tag, " done-early"}, 32'(done), 32'd0);
         checkOutput({tag, " hold-hi"}, 32'(P_hi), 32'(prevHi));
         checkOutput({tag, " hold-lo"}, 32'(P_lo), 32'(prevLo));
         if (k == glitch) begin
            start = 1'b1;
            A     = 16'd2;
            B     = 16'd2;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, " done"}, 32'(done), 32'd1);
      checkOutput({tag, " busy-at-done"}, 32'(busy), 32'd0);
      checkOutput({tag, " P_hi"}, 32'(P_hi), 32'(expHi));
      checkOutput({tag, " P_lo"}, 32'(P_lo), 32'(expLo));
      @(negedge clk);
      checkOutput({tag, " done-pulse"}, 32'(done), 32'd0);
      checkOutput({tag, " busy-after"}, 32'(busy), 32'd0);
      checkOutput({tag, " held-hi"}, 32'(P_hi), 32'(expHi));
      checkOutput({tag, " held-lo"}, 32'(P_lo), 32'(expLo));
      prevHi = expHi;
      prevLo = expLo;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      prevHi = '0;
      prevLo = '0;
      rst_n  = 1'b0;
      start  = 1'b0;
      A      = '0;
      B      = '0;

      // Check the reset state.
      #12;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset P_hi", 32'(P_hi), 32'd0);
      checkOutput("reset P_lo", 32'(P_lo), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // With start low, IDLE holds and operand changes do nothing.
      for (int i = 0; i < 3; i++) begin
         A = 16'h1111 * 16'(i + 1);
         B = 16'h0F0F;
         @(negedge clk);
         checkOutput("idle busy", 32'(busy), 32'd0);
         checkOutput("idle done", 32'(done), 32'd0);
      end

      // Basic case: 3*5 = 0x0000_000F.
      applyStimulus(16'd3, 16'd5, 16'h0000, 16'h000F, 0, "basic");

      // Maximum case: 0xFFFF*0xFFFF = 0xFFFE_0001.
      applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 0, "max");

      // The product holds through IDLE.
      repeat (3) begin
         @(negedge clk);
         checkOutput("idle hold hi", 32'(P_hi), 32'h0000FFFE);
         checkOutput("idle hold lo", 32'(P_lo), 32'h00000001);
      end

      // A zero multiplier gives a zero product and still takes the full
      // latency. The previous product is held until done.
      applyStimulus(16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, "zero");

      // A restart in BUSY cycle 5 is ignored: 7*9 = 0x3F.
      applyStimulus(16'd7, 16'd9, 16'h0000, 16'h003F, 5, "restart");
      repeat (4) begin
         @(negedge clk);
         checkOutput("no second op busy", 32'(busy), 32'd0);
         checkOutput("no second op done", 32'(done), 32'd0);
      end

      // Reset mid-operation at BUSY cycle 8.
      @(negedge clk);
      start = 1'b1;
      A     = 16'h0055;
      B     = 16'h0003;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("abort busy before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort P_hi", 32'(P_hi), 32'd0);
      checkOutput("abort P_lo", 32'(P_lo), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("post-abort done", 32'(done), 32'd0);
         checkOutput("post-abort busy", 32'(busy), 32'd0);
      end
      prevHi = '0;
      prevLo = '0;
      applyStimulus(16'd10, 16'd10, 16'h0000, 16'h0064, 0, "after-reset");

      // Back-to-back: with start held high, done appears every 18 cycles.
      @(negedge clk);
      start = 1'b1;
      A     = 16'h0100;
      B     = 16'h0100;
      for (int c = 1; c <= 54; c++) begin
         @(negedge clk);
         checkOutput("b2b done", 32'(done), ((c % 18) == 17) ? 32'd1 : 32'd0);
         if ((c % 18) == 17) begin
            checkOutput("b2b P_hi", 32'(P_hi), 32'h00000001);
            checkOutput("b2b P_lo", 32'(P_lo), 32'h00000000);
         end
      end
      start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
